// File: rtl/defender_input_pkg.sv
// Shared constants and state types for the Defender input conditioning stage.
//   - game select values carried on `mod`
//   - control mode encodings carried on `ctrl_mode`
//   - bit positions inside the packed joystick word
//   - state enums for the coin-pulse and reverse/thrust FSMs
package defender_input_pkg;

  // Game select
  localparam logic [7:0] MOD_DEFENDER = 8'd0;
  localparam logic [7:0] MOD_COLONY7  = 8'd1;
  localparam logic [7:0] MOD_MAYDAY   = 8'd2;
  localparam logic [7:0] MOD_JIN      = 8'd3;

  // Control mode
  localparam logic [1:0] CTRL_MODE1   = 2'b00;
  localparam logic [1:0] CTRL_MODE2   = 2'b01;
  localparam logic [1:0] CTRL_CABINET = 2'b10;

  // Joystick bit positions
  localparam int JOY_RIGHT    = 0;
  localparam int JOY_LEFT     = 1;
  localparam int JOY_DOWN     = 2;
  localparam int JOY_UP       = 3;
  localparam int JOY_FA       = 4;
  localparam int JOY_FB       = 5;
  localparam int JOY_FC       = 6;
  localparam int JOY_FD       = 7;
  localparam int JOY_FE       = 8;
  localparam int JOY_START1   = 9;
  localparam int JOY_START2   = 10;
  localparam int JOY_COIN     = 11;
  localparam int JOY_AUTOFIRE = 12;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_REL   = 2'd2
  } coin_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REV  = 2'd1,
    R_THR  = 2'd2,
    R_HOLD = 2'd3
  } rev_state_e;

endpackage

// File: rtl/input_sync2.sv
// Two-flop synchroniser for a bus of W bits, asynchronous active-low reset.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - bus from the foreign domain
//   q     - synchronised bus, two clk cycles behind d
module input_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/defender_input_ctl.sv
// Input conditioning between the HPS joystick/DIP path and the defender core's
// input0..2 ports, running in the clk_6 domain. Resynchronises clk_sys
// controls, stretches coin presses to a frame-timed pulse, runs the Mode 2
// joystick-to-reverse/thrust FSM for Defender and applies per-game bit maps.
//
// Optional feature: define DEFENDER_AUTOFIRE_EN to turn joy[12] into an
// autofire button on fire A (square wave, AUTOFIRE_FRAMES frames per half).
//
// Ports:
//   clk_6, reset_n      - core clock, asynchronous active-low reset
//   joy[31:0]           - joystick word (clk_sys domain)
//   mod[7:0]            - game select (clk_sys domain)
//   ctrl_mode[1:0]      - 00 Mode 1, 01 Mode 2, 10 Cabinet (clk_sys domain)
//   sw0/sw1/sw2[7:0]    - DIP bytes (clk_sys domain)
//   def_state           - ship facing from the core, 1 = facing left
//   vblank              - core vertical blank, rising edge is the frame tick
//   in0/in1/in2[7:0]    - registered inputs to the core
//   dbg_coin_state      - current coin FSM state
//   dbg_rev_state       - current reverse/thrust FSM state
module defender_input_ctl
  import defender_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES     = 3,
  parameter int unsigned REV_FRAMES      = 2,
  parameter int unsigned AUTOFIRE_FRAMES = 2
) (
  input  logic        clk_6,
  input  logic        reset_n,
  input  logic [31:0] joy,
  input  logic [7:0]  mod,
  input  logic [1:0]  ctrl_mode,
  input  logic [7:0]  sw0,
  input  logic [7:0]  sw1,
  input  logic [7:0]  sw2,
  input  logic        def_state,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output coin_state_e dbg_coin_state,
  output rev_state_e  dbg_rev_state
);

  localparam logic [7:0] COIN_LOAD = 8'(COIN_FRAMES);
  localparam logic [7:0] REV_LOAD  = 8'(REV_FRAMES);

  // Synchronised copies of the clk_sys controls
  logic [31:0] joy_s;
  logic [7:0]  mod_s;
  logic [1:0]  ctrl_s;
  logic [7:0]  sw0_s, sw1_s, sw2_s;

  input_sync2 #(.W(32)) u_sync_joy  (.clk(clk_6), .rst_n(reset_n), .d(joy),       .q(joy_s));
  input_sync2 #(.W(8))  u_sync_mod  (.clk(clk_6), .rst_n(reset_n), .d(mod),       .q(mod_s));
  input_sync2 #(.W(2))  u_sync_ctrl (.clk(clk_6), .rst_n(reset_n), .d(ctrl_mode), .q(ctrl_s));
  input_sync2 #(.W(8))  u_sync_sw0  (.clk(clk_6), .rst_n(reset_n), .d(sw0),       .q(sw0_s));
  input_sync2 #(.W(8))  u_sync_sw1  (.clk(clk_6), .rst_n(reset_n), .d(sw1),       .q(sw1_s));
  input_sync2 #(.W(8))  u_sync_sw2  (.clk(clk_6), .rst_n(reset_n), .d(sw2),       .q(sw2_s));

  logic        vblank_q,    vblank_d;
  logic [7:0]  mod_q,       mod_d;
  logic        coin_prev_q, coin_prev_d;
  logic [1:0]  settle_q,    settle_d;
  coin_state_e coin_state_q, coin_state_d;
  logic [7:0]  coin_cnt_q,  coin_cnt_d;
  rev_state_e  rev_state_q, rev_state_d;
  logic [7:0]  rev_cnt_q,   rev_cnt_d;
  logic [7:0]  in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;

  logic right, left, down, up, fa, fb, fc, fd, fe, s1, s2, coin_raw;
  logic ftick, mod_chg, coin_rise;
  logic rev_active, dir_held, dir_left, rev_match;
  logic coin_out, reverse, thrust, x_bit, y_bit;
  logic [7:0] map1, map2;

  logic unused_joy;
  assign unused_joy = ^joy_s[31:13];

`ifdef DEFENDER_AUTOFIRE_EN
  logic       af_btn;
  logic       af_phase_q, af_phase_d;
  logic [7:0] af_cnt_q,   af_cnt_d;

  assign af_btn = joy_s[JOY_AUTOFIRE];

  // Phase starts high on press; each AUTOFIRE_FRAMES ticks flips it.
  always_comb begin
    af_phase_d = af_phase_q;
    af_cnt_d   = af_cnt_q;
    if (!af_btn) begin
      af_phase_d = 1'b1;
      af_cnt_d   = '0;
    end else if (ftick) begin
      if (af_cnt_q + 8'd1 >= 8'(AUTOFIRE_FRAMES)) begin
        af_phase_d = ~af_phase_q;
        af_cnt_d   = '0;
      end else begin
        af_cnt_d = af_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      af_phase_q <= 1'b1;
      af_cnt_q   <= '0;
    end else begin
      af_phase_q <= af_phase_d;
      af_cnt_q   <= af_cnt_d;
    end
  end

  assign fa = joy_s[JOY_FA] | (af_btn & af_phase_q);
`else
  logic [8:0] unused_af;
  assign unused_af = {joy_s[JOY_AUTOFIRE], 8'(AUTOFIRE_FRAMES)};
  assign fa = joy_s[JOY_FA];
`endif

  assign right    = joy_s[JOY_RIGHT];
  assign left     = joy_s[JOY_LEFT];
  assign down     = joy_s[JOY_DOWN];
  assign up       = joy_s[JOY_UP];
  assign fb       = joy_s[JOY_FB];
  assign fc       = joy_s[JOY_FC];
  assign fd       = joy_s[JOY_FD];
  assign fe       = joy_s[JOY_FE];
  assign s1       = joy_s[JOY_START1];
  assign s2       = joy_s[JOY_START2];
  assign coin_raw = joy_s[JOY_COIN];

  always_comb begin
    vblank_d = vblank;
    mod_d    = mod_s;
    settle_d = {settle_q[0], 1'b1};
    // Until the synchroniser has flushed, pretend the coin was already held:
    // a coin held through reset must not produce a pulse.
    coin_prev_d = settle_q[1] ? coin_raw : 1'b1;

    ftick     = vblank & ~vblank_q;
    mod_chg   = (mod_s != mod_q);
    coin_rise = coin_raw & ~coin_prev_q;

    // Coin FSM
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    if (mod_chg) begin
      coin_state_d = C_REL;
      coin_cnt_d   = '0;
    end else begin
      case (coin_state_q)
        C_IDLE: begin
          // A tick on the entry cycle is not counted: the load wins.
          if (coin_rise) begin
            coin_state_d = C_PULSE;
            coin_cnt_d   = COIN_LOAD;
          end
        end
        C_PULSE: begin
          if (ftick) begin
            if (coin_cnt_q <= 8'd1) begin
              coin_state_d = C_REL;
              coin_cnt_d   = '0;
            end else begin
              coin_cnt_d = coin_cnt_q - 8'd1;
            end
          end
        end
        C_REL: begin
          if (!coin_raw) coin_state_d = C_IDLE;
        end
        default: begin
          coin_state_d = C_IDLE;
          coin_cnt_d   = '0;
        end
      endcase
    end

    // Reverse/thrust FSM: right wins when both directions are held.
    rev_active = (mod_s == MOD_DEFENDER) && (ctrl_s == CTRL_MODE2);
    dir_held   = right | left;
    dir_left   = ~right & left;
    rev_match  = dir_held & (dir_left == def_state);

    rev_state_d = rev_state_q;
    rev_cnt_d   = rev_cnt_q;
    if (!rev_active || mod_chg) begin
      rev_state_d = R_IDLE;
      rev_cnt_d   = '0;
    end else begin
      case (rev_state_q)
        R_IDLE: begin
          if (rev_match) begin
            rev_state_d = R_THR;
          end else if (dir_held) begin
            rev_state_d = R_REV;
            rev_cnt_d   = REV_LOAD;
          end
        end
        R_REV: begin
          if (rev_match) begin
            rev_state_d = R_THR;
            rev_cnt_d   = '0;
          end else if (ftick) begin
            if (rev_cnt_q <= 8'd1) begin
              rev_state_d = R_HOLD;
              rev_cnt_d   = '0;
            end else begin
              rev_cnt_d = rev_cnt_q - 8'd1;
            end
          end
        end
        R_THR: begin
          if (!dir_held) begin
            rev_state_d = R_IDLE;
          end else if (!rev_match) begin
            rev_state_d = R_REV;
            rev_cnt_d   = REV_LOAD;
          end
        end
        R_HOLD: begin
          if (rev_match)      rev_state_d = R_THR;
          else if (!dir_held) rev_state_d = R_IDLE;
        end
        default: begin
          rev_state_d = R_IDLE;
          rev_cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they line up with the state register.
    coin_out = (coin_state_d == C_PULSE);
    reverse  = (rev_state_d == R_REV);
    thrust   = (rev_state_d == R_THR);

    case (ctrl_s)
      CTRL_MODE2:   begin x_bit = reverse; y_bit = thrust; end
      CTRL_CABINET: begin x_bit = fe;      y_bit = fb;     end
      default:      begin x_bit = left | right; y_bit = fb; end
    endcase

    map1 = '0;
    map2 = '0;
    case (mod_s)
      MOD_DEFENDER: begin
        map1 = {down, x_bit, s1, s2, fd, fc, y_bit, fa};
        map2 = {7'b0, up};
      end
      MOD_COLONY7: begin
        map1 = {fb, fa, s1, s2, up, left, right, down};
        map2 = {7'b0, fc};
      end
      MOD_MAYDAY: begin
        map1 = {down, 1'b0, s1, s2, fb, fc, right, fa};
        map2 = {7'b0, up};
      end
      MOD_JIN: begin
        map1 = {fb, fa, s1, s2, right, left, down, up};
      end
      default: begin
        map1 = '0;
        map2 = '0;
      end
    endcase

    in0_d = sw0_s | {3'b0, coin_out, 4'b0};
    in1_d = sw1_s | map1;
    in2_d = sw2_s | map2;
  end

  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q     <= 1'b0;
      mod_q        <= '0;
      coin_prev_q  <= 1'b1;
      settle_q     <= '0;
      coin_state_q <= C_IDLE;
      coin_cnt_q   <= '0;
      rev_state_q  <= R_IDLE;
      rev_cnt_q    <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
    end else begin
      vblank_q     <= vblank_d;
      mod_q        <= mod_d;
      coin_prev_q  <= coin_prev_d;
      settle_q     <= settle_d;
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      rev_state_q  <= rev_state_d;
      rev_cnt_q    <= rev_cnt_d;
      in0_q        <= in0_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
    end
  end

  assign in0            = in0_q;
  assign in1            = in1_q;
  assign in2            = in2_q;
  assign dbg_coin_state = coin_state_q;
  assign dbg_rev_state  = rev_state_q;

endmodule

// File: tb/tb_defender_input_ctl.sv
// Directed bench for defender_input_ctl: reset values, DIP/joystick latency,
// coin pulse timing, Mode 2 reverse/thrust, per-game maps, reset mid-pulse
// and the autofire bit.
module tb_defender_input_ctl;
  import defender_input_pkg::*;

  localparam int FRAME_LEN = 8;

  logic        clk_6;
  logic        reset_n;
  logic [31:0] joy;
  logic [7:0]  mod;
  logic [1:0]  ctrl_mode;
  logic [7:0]  sw0, sw1, sw2;
  logic        def_state;
  logic        vblank;
  logic [7:0]  in0, in1, in2;
  coin_state_e dbg_coin_state;
  rev_state_e  dbg_rev_state;

  int checks = 0;
  int errors = 0;

  defender_input_ctl #(
    .COIN_FRAMES(3),
    .REV_FRAMES(2),
    .AUTOFIRE_FRAMES(2)
  ) dut (
    .clk_6(clk_6),
    .reset_n(reset_n),
    .joy(joy),
    .mod(mod),
    .ctrl_mode(ctrl_mode),
    .sw0(sw0),
    .sw1(sw1),
    .sw2(sw2),
    .def_state(def_state),
    .vblank(vblank),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .dbg_coin_state(dbg_coin_state),
    .dbg_rev_state(dbg_rev_state)
  );

  // Clock / reset block
  initial clk_6 = 1'b0;
  always #5 clk_6 = ~clk_6;

  // Advance n rising edges and settle just after the last one.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk_6);
    #1;
  endtask

  // One frame: vblank high for one cycle, then low for the rest.
  task automatic frame();
    vblank = 1'b1;
    tick_n(1);
    vblank = 1'b0;
    tick_n(FRAME_LEN - 1);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] af_exp;

  initial begin
    reset_n = 1'b0; joy = '0; mod = 8'd0; ctrl_mode = 2'b00;
    sw0 = '0; sw1 = '0; sw2 = '0; def_state = 1'b0; vblank = 1'b0;
    tick_n(2);
    check8("reset_in0", in0, 8'h00);
    check8("reset_in1", in1, 8'h00);
    check8("reset_in2", in2, 8'h00);
    check8("reset_coin_st", 8'(dbg_coin_state), 8'(C_IDLE));
    check8("reset_rev_st", 8'(dbg_rev_state), 8'(R_IDLE));
    reset_n = 1'b1;
    tick_n(4);

    // DIP path: three cycles to the outputs
    sw0 = 8'hA5; sw1 = 8'h01; sw2 = 8'h80;
    tick_n(2);
    check8("dip_lat2_in1", in1, 8'h00);
    tick_n(1);
    check8("dip_in0", in0, 8'hA5);
    check8("dip_in1", in1, 8'h01);
    check8("dip_in2", in2, 8'h80);
    sw0 = '0; sw1 = '0; sw2 = '0;
    tick_n(3);

    // Defender Mode 1: left -> X (bit 6)
    joy = 32'h0000_0002;
    tick_n(3);
    check8("m1_left", in1, 8'h40);
    // Cabinet: fe -> bit 6, fb -> bit 1
    ctrl_mode = 2'b10; joy = 32'h0000_0120;
    tick_n(3);
    check8("cab_fe_fb", in1, 8'h42);
    joy = '0; ctrl_mode = 2'b00;
    tick_n(3);

    // Coin held for 10 frames: high through two ticks, drops on the third
    joy = 32'h0000_0800;
    tick_n(2);
    check8("coin_lat2", in0, 8'h00);
    tick_n(1);
    check8("coin_rise", in0, 8'h10);
    for (int k = 0; k < 10; k++) begin
      frame();
      check8($sformatf("coin_frame%0d", k), in0, (k < 2) ? 8'h10 : 8'h00);
    end
    check8("coin_rel_st", 8'(dbg_coin_state), 8'(C_REL));
    joy = '0;
    tick_n(3);
    check8("coin_idle_st", 8'(dbg_coin_state), 8'(C_IDLE));

    // Second press with the entry coinciding with a frame tick
    joy = 32'h0000_0800;
    tick_n(2);
    vblank = 1'b1;
    tick_n(1);
    vblank = 1'b0;
    check8("coin2_rise", in0, 8'h10);
    tick_n(1);
    frame();
    check8("coin2_f1", in0, 8'h10);
    frame();
    check8("coin2_f2", in0, 8'h10);
    frame();
    check8("coin2_f3", in0, 8'h00);
    joy = '0;
    tick_n(3);

    // Mode 2 reverse/thrust, facing left, pushing right
    ctrl_mode = 2'b01; def_state = 1'b1;
    tick_n(3);
    check8("m2_idle", in1, 8'h00);
    joy = 32'h0000_0001;
    tick_n(3);
    check8("m2_rev", in1, 8'h40);
    check8("m2_rev_st", 8'(dbg_rev_state), 8'(R_REV));
    frame();
    check8("m2_rev_f1", in1, 8'h40);
    def_state = 1'b0;
    tick_n(1);
    check8("m2_thr", in1, 8'h02);
    check8("m2_thr_st", 8'(dbg_rev_state), 8'(R_THR));
    def_state = 1'b1;
    tick_n(1);
    check8("m2_rev2", in1, 8'h40);
    frame();
    check8("m2_rev2_f1", in1, 8'h40);
    frame();
    check8("m2_hold", in1, 8'h00);
    check8("m2_hold_st", 8'(dbg_rev_state), 8'(R_HOLD));
    def_state = 1'b0;
    tick_n(1);
    check8("m2_hold_thr", in1, 8'h02);
    joy = '0;
    tick_n(3);
    check8("m2_release", in1, 8'h00);
    check8("m2_release_st", 8'(dbg_rev_state), 8'(R_IDLE));

    // Other games
    ctrl_mode = 2'b00; mod = 8'd3; joy = 32'h0000_0028;
    tick_n(3);
    check8("jin_in1", in1, 8'h81);
    check8("jin_in2", in2, 8'h00);
    mod = 8'd1; joy = 32'h0000_0040;
    tick_n(3);
    check8("col7_in1", in1, 8'h00);
    check8("col7_in2", in2, 8'h01);
    mod = 8'd2; joy = 32'h0000_0011;
    tick_n(3);
    check8("mayday_in1", in1, 8'h03);
    check8("mayday_in2", in2, 8'h00);
    mod = 8'd7; joy = 32'h0000_0008;
    tick_n(3);
    check8("badmod_in1", in1, 8'h00);
    check8("badmod_in2", in2, 8'h00);
    mod = 8'd0; joy = '0;
    tick_n(4);

    // Mod change while a coin pulse is running kills it
    joy = 32'h0000_0800;
    tick_n(3);
    check8("modchg_pulse", in0, 8'h10);
    mod = 8'd1;
    tick_n(3);
    check8("modchg_drop", in0, 8'h00);
    check8("modchg_st", 8'(dbg_coin_state), 8'(C_REL));
    mod = 8'd0;
    tick_n(4);
    joy = '0;
    tick_n(3);

    // Autofire on joy[12]: per-frame samples of in1[0]
    joy = 32'h0000_1000;
    tick_n(3);
    for (int k = 0; k < 8; k++) begin
`ifdef DEFENDER_AUTOFIRE_EN
      af_exp = ((k / 2) % 2 == 0) ? 8'h01 : 8'h00;
`else
      af_exp = 8'h00;
`endif
      check8($sformatf("autofire%0d", k), {7'b0, in1[0]}, af_exp);
      frame();
    end
    joy = '0;
    tick_n(3);

    // Reset during a coin pulse and a reverse pulse
    ctrl_mode = 2'b01; def_state = 1'b1; joy = 32'h0000_0801;
    tick_n(3);
    check8("pre_rst_in0", in0, 8'h10);
    check8("pre_rst_in1", in1, 8'h40);
    #2;
    reset_n = 1'b0;
    #1;
    check8("rst_in0", in0, 8'h00);
    check8("rst_in1", in1, 8'h00);
    check8("rst_in2", in2, 8'h00);
    check8("rst_coin_st", 8'(dbg_coin_state), 8'(C_IDLE));
    check8("rst_rev_st", 8'(dbg_rev_state), 8'(R_IDLE));
    joy = 32'h0000_0800;
    tick_n(2);
    reset_n = 1'b1;
    tick_n(6);
    check8("held_coin_in0", in0, 8'h00);
    check8("held_coin_st", 8'(dbg_coin_state), 8'(C_IDLE));
    joy = '0;
    tick_n(3);
    joy = 32'h0000_0800;
    tick_n(3);
    check8("repress_in0", in0, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/defender_input_ctl.md
# defender_input_ctl

Input conditioning stage between the HPS joystick/DIP path and the `defender` core's `input0..2` ports; runs in the `clk_6` domain. It resynchronises `clk_sys`-domain controls and applies the per-game bit maps. It also adds frame-timed behaviour: a minimum-width coin pulse and the Mode 2 joystick-to-reverse/thrust state machine for Defender.

## Interface
- `COIN_FRAMES`, 3: minimum coin-switch assertion, in frames
- `REV_FRAMES`, 2: reverse-button pulse width, in frames
- `AUTOFIRE_FRAMES`, 2: autofire half-period, in frames (used only with the macro)

- `clk_6`  in  1  core clock, 6 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `joy`  in  32  joy1|joy2, `clk_sys` domain; bits 0 right, 1 left, 2 down, 3 up, 4–8 fire a–e, 9 start1, 10 start2, 11 coin, 12 autofire
- `mod`  in  8  game select, `clk_sys` domain: 0 defender, 1 colony7, 2 mayday, 3 jin
- `ctrl_mode`  in  2  control mode: 00 Mode 1, 01 Mode 2, 10 Cabinet
- `sw0`, `sw1`, `sw2`  in  8 each  DIP bytes, `clk_sys` domain
- `def_state`  in  1  ship facing from the core; 1 means facing left
- `vblank`  in  1  core vertical blank
- `in0`, `in1`, `in2`  out  8 each  registered inputs to the core

## Operation
- **Synchronisation.** `joy`, `mod`, `ctrl_mode` and `sw*` pass through two flops each. `def_state` and `vblank` are already in the `clk_6` domain.
- **Frame tick.** `ftick` is high for one cycle on each rising edge of `vblank`.
- **Coin FSM.**
  - C_IDLE: a rising edge on coin goes to C_PULSE and loads the counter with `COIN_FRAMES`.
  - C_PULSE: coin is driven high. Each `ftick` decrements the counter. At 0 go to C_REL.
  - C_REL: coin is driven low. Return to C_IDLE once the raw coin input is 0.
  - Holding the coin button therefore gives exactly one pulse.
- **Reverse FSM.** Active only when mod=0 and ctrl_mode=01; otherwise it is forced to R_IDLE. `dir` is right or left; right takes priority when both are held. `match` means `dir` agrees with `def_state`.
  - R_IDLE: `dir` held and match goes to R_THR. `dir` held and not match goes to R_REV and loads `REV_FRAMES`.
  - R_REV: reverse=1, thrust=0. Decrement on `ftick`. If match becomes true, go to R_THR immediately. If the count expires without match, go to R_HOLD.
  - R_THR: thrust=1 while `dir` is held and match. A mismatch goes to R_REV. Release goes to R_IDLE.
  - R_HOLD: no outputs. Leave to R_THR on match or to R_IDLE on release.
- **Bit maps.** `in0 = sw0 | {3'b0, coin, 4'b0}`. `in1 = sw1 | map1`. `in2 = sw2 | map2`.
  - defender, `map1 = {down, X, s1, s2, fd, fc, Y, fa}`, `map2[0] = up`:
    - Mode 1: X = left|right, Y = fb
    - Mode 2: X = reverse, Y = thrust
    - Cabinet: X = fe, Y = fb
  - colony7: `map1 = {fb, fa, s1, s2, up, left, right, down}`, `map2[0] = fc`
  - mayday: `map1 = {down, 0, s1, s2, fb, fc, right, fa}`, `map2[0] = up`
  - jin: `map1 = {fb, fa, s1, s2, right, left, down, up}`, `map2 = 0`
  - Any other mod value gives `map1 = map2 = 0`.
- **Mod change.** When `mod` changes, both FSMs return to idle. The coin FSM goes to C_REL so that a held coin is not replayed.

## Timing
- While `reset_n` is low: `in0`, `in1`, `in2` = 8'h00, synchronisers clear, FSMs in C_IDLE / R_IDLE, counters 0.
- Joystick or DIP change to output: 3 `clk_6` cycles (2 sync flops plus the output register).
- The coin output rises 3 cycles after the raw coin edge. It stays high for `COIN_FRAMES` frame ticks after entry, ±1 frame of phase.
- Reverse pulse width: `REV_FRAMES` frame ticks, unless cut short by match.
- A coin edge arriving on the same cycle as `ftick` counts the tick only from the next one.
- An async reset mid-pulse drops every output the same cycle.

## Configuration
- With `DEFENDER_AUTOFIRE_EN` defined:
  - While `joy[12]` is held, `fa` is replaced by a square wave: high for `AUTOFIRE_FRAMES` frames, then low for the same.
  - The phase counter resets when bit 12 is released.
  - `fa` from bit 4 is OR'd into the result.
- Without the macro: bit 12 is ignored, the `AUTOFIRE_FRAMES` logic is absent, and `fa` = `joy[4]`.

## Structure
- Package `defender_input_pkg` holds:
  - mod localparams: MOD_DEFENDER, MOD_COLONY7, MOD_MAYDAY, MOD_JIN
  - ctrl_mode localparams
  - joystick bit-index constants
  - enum typedefs for the coin FSM and reverse FSM states
- Sub-module `input_sync2`: a parameterised-width two-flop synchroniser with asynchronous active-low reset, instantiated once per synchronised bus.

## Test plan
- Hold coin (`joy[11]`=1) for 10 frames, `COIN_FRAMES`=3 → `in0[4]`=1 for exactly 3 frame ticks, then 0 until release; a second press gives a second pulse.
- mod=0, ctrl_mode=01, `def_state`=1, right held → `in1[6]`=1 for 2 frames and `in1[1]`=0; then set `def_state`=1→0 mid-pulse → next cycle R_THR and `in1[1]`=1.
- mod=0, ctrl_mode=00, left held, `sw1`=8'h00 → `in1`=8'h40; `sw1`=8'h01 with no joystick → `in1`=8'h01 after 3 cycles.
- mod=3, up+fb held → `in1`=8'h81, `in2`=8'h00; mod switched to 1 with fc held → `in2`=8'h01.
- Assert `reset_n`=0 during an active coin pulse and during R_REV → all outputs 0 immediately; after release, FSMs idle and a held coin does not pulse until re-pressed.
- With `DEFENDER_AUTOFIRE_EN`, hold `joy[12]` for 8 frames → `in1[0]` pattern 1,1,0,0,1,1,0,0 per frame; without the macro `in1[0]` stays 0.
